hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline sequencing unit for the 5-stage core.
- Drives enable and flush (synchronous clear) for PC, F/D, D/E, E/M and M/W pipeline registers, including the decode-to-execute control register.
- Detects load-use and control hazards, selects E-stage operand forwarding, and freezes the whole pipeline while data memory is busy, with a timeout watchdog.
- Keeps stall and flush performance counters.

Parameters:
- ADDR_WIDTH, 5, register index width.
- TIMEOUT, 64, max consecutive memory-wait cycles before error.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- Rs1D, Rs2D  in  ADDR_WIDTH  D-stage source registers
- Rs1E, Rs2E  in  ADDR_WIDTH  E-stage source registers
- RdE, RdM, RdW  in  ADDR_WIDTH  destination registers in E/M/W
- ResultSrcE  in  2  E-stage result select; 2'b01 = load
- RegWriteM, RegWriteW  in  1  register write pending in M/W (OR of codebase RegWrite field)
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM  in  1  load/store in M
- MemReadyM  in  1  data memory completes access this cycle
- EnPC, EnFD, EnDE, EnEM, EnMW  out  1  register enables
- FlushFD, FlushDE  out  1  clear F/D, D/E at next edge (only effective while matching enable high)
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- MemErr  out  1  sticky memory timeout error
- StallCnt, FlushCnt  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (rst=0, async): state RUN, wait counter 0, MemErr 0, StallCnt 0, FlushCnt 0. Combinational outputs evaluate normally.
- Forwarding (combinational), operand A, same for B with Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00.
  - M has priority over W.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
  - A taken branch overrides load-use so the PC can load the target.
- freeze = (MemReqM && !MemReadyM) || state==ERROR.
- Output priority (combinational, same cycle):
  - freeze: all En*=0, FlushFD=0, FlushDE=0.
  - else PCSrcE: all En*=1, FlushFD=1, FlushDE=1.
  - else lwStall: EnPC=0, EnFD=0, EnDE=1, FlushDE=1 (bubble), EnEM=EnMW=1.
  - else: all En*=1, no flush.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM; wait counter <= 1.
  - MEM_WAIT: counter increments each cycle with !MemReadyM. On MemReadyM -> RUN, counter <= 0; the pipeline advances in that same cycle (freeze already low). If counter==TIMEOUT-1 and !MemReadyM -> ERROR.
  - ERROR: MemErr=1, pipeline frozen; exits only via reset.
- Counters:
  - StallCnt +1 each cycle where freeze || lwStall.
  - FlushCnt +1 each cycle where FlushFD || FlushDE is effective (i.e. not frozen).
  - Both wrap modulo 2^CNT_WIDTH. No counting in ERROR.
- A branch in E during a freeze stays in E (EnEM=0); its flush is applied on the first unfrozen cycle. No pending register is needed.
- Reset asserted mid-wait returns to RUN immediately. The counter clears.

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5, PCSrcE=0 -> EnPC=0, EnFD=0, FlushDE=1 for one cycle; StallCnt increments by 1.
- Forward priority: RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7 -> ForwardAE=10. Clear RegWriteM -> 01. With RdM=RdW=0 -> 00.
- Branch+load-use together: PCSrcE=1 plus load-use match -> EnPC=1, FlushFD=1, FlushDE=1; FlushCnt +1, StallCnt unchanged.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> all En*=0 for 3 cycles, state RUN->MEM_WAIT->RUN; StallCnt +3; pipeline advances on ready cycle.
- Timeout: TIMEOUT=4, MemReadyM never rises -> MemErr=1 on edge after 4th wait cycle, enables stay 0. rst=0 clears MemErr, counters and state.
- Branch during freeze: PCSrcE=1 with MemReqM=1, MemReadyM=0 for 2 cycles -> no flush during freeze; FlushFD=FlushDE=1 on the cycle MemReadyM=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: forwarding, load-use and branch hazards,
// data-memory wait freeze with a timeout watchdog, and stall/flush performance counters.
module hazard_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] Rs1E,
    input  logic [ADDR_WIDTH-1:0] Rs2E,
    input  logic [ADDR_WIDTH-1:0] RdE,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  EnPC,
    output logic                  EnFD,
    output logic                  EnDE,
    output logic                  EnEM,
    output logic                  EnMW,
    output logic                  FlushFD,
    output logic                  FlushDE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemErr,
    output logic [CNT_WIDTH-1:0]  StallCnt,
    output logic [CNT_WIDTH-1:0]  FlushCnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;
    logic              memStall;
    logic              freeze;
    logic              lwStall;

    assign memStall = MemReqM && !MemReadyM;
    assign freeze   = memStall || (state == ERROR);
    assign MemErr   = (state == ERROR);

    // A taken branch wins over load-use so the PC is free to load the target.
    assign lwStall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    // Freeze dominates so a branch held in E keeps its flush until the first unfrozen cycle.
    always_comb begin
        EnPC    = 1'b1;
        EnFD    = 1'b1;
        EnDE    = 1'b1;
        EnEM    = 1'b1;
        EnMW    = 1'b1;
        FlushFD = 1'b0;
        FlushDE = 1'b0;
        if (freeze) begin
            EnPC = 1'b0;
            EnFD = 1'b0;
            EnDE = 1'b0;
            EnEM = 1'b0;
            EnMW = 1'b0;
        end else if (PCSrcE) begin
            FlushFD = 1'b1;
            FlushDE = 1'b1;
        end else if (lwStall) begin
            EnPC    = 1'b0;
            EnFD    = 1'b0;
            FlushDE = 1'b1;
        end
    end

    // Wait counter holds the number of consecutive unready cycles seen so far.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            RUN: begin
                if (memStall) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                    stateNext = ERROR;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                stateNext = ERROR;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (state != ERROR) begin
            if (freeze || lwStall)
                StallCnt <= StallCnt + CNT_WIDTH'(1);
            if (FlushFD || FlushDE)
                FlushCnt <= FlushCnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short watchdog (TIMEOUT=4) so the error path is reachable.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        EnPC, EnFD, EnDE, EnEM, EnMW, FlushFD, FlushDE, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.ADDR_WIDTH(5), .TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .EnPC(EnPC), .EnFD(EnFD), .EnDE(EnDE), .EnEM(EnEM), .EnMW(EnMW),
        .FlushFD(FlushFD), .FlushDE(FlushDE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 2'b00;
        RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_stall", StallCnt, 0);
        checkOutput("rst_flush", FlushCnt, 0);
        checkOutput("rst_memerr", MemErr, 0);
        checkOutput("rst_enpc", EnPC, 1);
        tick();
        rst = 1'b1;
        tick();

        // Forwarding priority M over W, then W alone, then register zero.
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7; #1;
        checkOutput("fwdA_M", ForwardAE, 2'b10);
        checkOutput("fwdB_M", ForwardBE, 2'b10);
        RegWriteM = 0; #1;
        checkOutput("fwdA_W", ForwardAE, 2'b01);
        RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; #1;
        checkOutput("fwdA_zero", ForwardAE, 2'b00);
        applyStimulus();

        // Load-use bubble for one cycle.
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; #1;
        checkOutput("lu_enpc", EnPC, 0);
        checkOutput("lu_enfd", EnFD, 0);
        checkOutput("lu_ende", EnDE, 1);
        checkOutput("lu_flushde", FlushDE, 1);
        checkOutput("lu_flushfd", FlushFD, 0);
        tick();
        checkOutput("lu_stallcnt", StallCnt, 1);
        checkOutput("lu_flushcnt", FlushCnt, 1);
        applyStimulus();

        // Load-use against x0 is not a hazard.
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; #1;
        checkOutput("lu_x0_enpc", EnPC, 1);
        applyStimulus();

        // Branch overrides load-use.
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; PCSrcE = 1; #1;
        checkOutput("br_enpc", EnPC, 1);
        checkOutput("br_flushfd", FlushFD, 1);
        checkOutput("br_flushde", FlushDE, 1);
        tick();
        checkOutput("br_flushcnt", FlushCnt, 2);
        checkOutput("br_stallcnt", StallCnt, 1);
        applyStimulus();

        // Memory wait of three cycles, pipeline advances on the ready cycle.
        MemReqM = 1; MemReadyM = 0; #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("mw_enpc", EnPC, 0);
            checkOutput("mw_enmw", EnMW, 0);
            tick();
        end
        checkOutput("mw_stallcnt", StallCnt, 4);
        MemReadyM = 1; #1;
        checkOutput("mw_ready_enpc", EnPC, 1);
        checkOutput("mw_ready_enem", EnEM, 1);
        tick();
        checkOutput("mw_after_stall", StallCnt, 4);
        applyStimulus();

        // Branch held in E while frozen, flushed on the ready cycle.
        PCSrcE = 1; MemReqM = 1; MemReadyM = 0; #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("bf_flushfd", FlushFD, 0);
            checkOutput("bf_enem", EnEM, 0);
            tick();
        end
        checkOutput("bf_flushcnt_hold", FlushCnt, 2);
        MemReadyM = 1; #1;
        checkOutput("bf_rdy_flushfd", FlushFD, 1);
        checkOutput("bf_rdy_flushde", FlushDE, 1);
        tick();
        checkOutput("bf_flushcnt", FlushCnt, 3);
        checkOutput("bf_stallcnt", StallCnt, 6);
        applyStimulus();

        // Watchdog: four unready cycles raise MemErr.
        MemReqM = 1; MemReadyM = 0; #1;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("to_memerr_early", MemErr, 0);
        tick();
        checkOutput("to_memerr", MemErr, 1);
        checkOutput("to_stallcnt", StallCnt, 10);
        MemReqM = 0; MemReadyM = 1; #1;
        checkOutput("to_enpc", EnPC, 0);
        tick();
        checkOutput("to_sticky", MemErr, 1);
        checkOutput("to_nocount", StallCnt, 10);

        // Asynchronous reset clears error and counters.
        applyStimulus();
        rst = 1'b0; #1;
        checkOutput("rst2_memerr", MemErr, 0);
        checkOutput("rst2_stall", StallCnt, 0);
        checkOutput("rst2_flush", FlushCnt, 0);
        checkOutput("rst2_enpc", EnPC, 1);
        rst = 1'b1;
        tick();

        // Reset mid-wait restarts the watchdog count.
        MemReqM = 1; MemReadyM = 0; #1;
        tick(); tick();
        rst = 1'b0; #1;
        rst = 1'b1; #1;
        tick(); tick(); tick();
        checkOutput("mid_rst_memerr", MemErr, 0);
        checkOutput("mid_rst_stall", StallCnt, 3);
        applyStimulus();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
